// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the main control unit and the shared mult/div engine.
// The control unit is the master; the engine is the slave.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output mult_start, div_start, a, b,
        input  hi, lo, busy, done, divzero
    );

    modport slave (
        input  mult_start, div_start, a, b,
        output hi, lo, busy, done, divzero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine.
// One bit per cycle; the result lands in HI/LO on entry to DONE.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    mult_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_MULT = 4'b0010,
        S_DIV  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    // Booth register {P_hi, P_lo, q-1}; P_hi carries one guard bit so that
    // subtracting the most-negative multiplicand cannot overflow.
    logic [2*WIDTH+1:0] r_acc;
    logic [WIDTH:0]     r_mcand;
    logic [WIDTH-1:0]   r_rem, r_quo, r_dvsr, r_hi, r_lo;
    logic               r_qneg, r_rneg, r_divzero;

    logic               w_busy, w_done, w_last, w_div_go, w_div_zero;
    logic [WIDTH:0]     w_p_hi, w_sum;
    logic [2*WIDTH+1:0] w_booth;
    logic [WIDTH:0]     w_rsh;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_diff, w_rem_nx, w_quo_nx, w_rem_s, w_quo_s;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_div_go   = bus.div_start && !bus.mult_start && (bus.b != '0);
    assign w_div_zero = bus.div_start && !bus.mult_start && (bus.b == '0);
    assign w_abs_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_abs_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Booth step: add/subtract on {P_lo[0], q-1}, then arithmetic shift right.
    assign w_p_hi = r_acc[2*WIDTH+1:WIDTH+1];
    always_comb begin
        w_sum = w_p_hi;
        case (r_acc[1:0])
            2'b01:   w_sum = w_p_hi + r_mcand;
            2'b10:   w_sum = w_p_hi - r_mcand;
            default: w_sum = w_p_hi;
        endcase
    end
    assign w_booth = {w_sum[WIDTH], w_sum, r_acc[WIDTH:1]};

    // Restoring step on magnitudes; the low bits of the modular difference are
    // exact whenever no borrow occurs, so a separate compare provides the borrow.
    assign w_rsh    = {r_rem, r_quo[WIDTH-1]};
    assign w_borrow = (w_rsh < {1'b0, r_dvsr});
    assign w_diff   = w_rsh[WIDTH-1:0] - r_dvsr;
    assign w_rem_nx = w_borrow ? w_rsh[WIDTH-1:0] : w_diff;
    assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_borrow};
    assign w_quo_s  = r_qneg ? -w_quo_nx : w_quo_nx;
    assign w_rem_s  = r_rneg ? -w_rem_nx : w_rem_nx;

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mult_start)  w_next = S_MULT;
                else if (w_div_go)   w_next = S_DIV;
            end
            S_MULT: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DIV: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_divzero <= (r_state == S_IDLE) && w_div_zero;
            case (r_state)
                S_IDLE: begin
                    if (bus.mult_start) begin
                        r_acc   <= {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
                        r_mcand <= {bus.a[WIDTH-1], bus.a};
                        r_cnt   <= '0;
                    end else if (w_div_go) begin
                        r_rem  <= '0;
                        r_quo  <= w_abs_a;
                        r_dvsr <= w_abs_b;
                        r_qneg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_rneg <= bus.a[WIDTH-1];
                        r_cnt  <= '0;
                    end
                end
                S_MULT: begin
                    r_acc <= w_booth;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi <= w_booth[2*WIDTH:WIDTH+1];
                        r_lo <= w_booth[WIDTH:1];
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi <= w_rem_s;
                        r_lo <= w_quo_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.divzero = r_divzero;
endmodule
